pp_accumulator: RTL and testbench

Sequential consumer of binary partial products: accepts one W+1-bit partial product per handshake, least-significant multiplier bit first. Each is weighted by its bit index and summed into a 2W+1-bit product, presented on a valid/ready output port. Sits downstream of the binary partial product generator and pairs with it to form a bit-serial shift-add multiplier. It drives `pp_index` so the upstream stage knows which multiplier bit to apply next.

---
 rtl/pp_accumulator.sv | 93 +++++++++
 tb/tb_pp_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// Shift-add accumulator for bit-serial multiplication.
// Sums W partial products, LSB first, into a 2W+1-bit product.
module pp_accumulator #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pp_valid,
  output logic          pp_ready,
  input  logic [W:0]    pp,
  output logic [CW-1:0] pp_index,
  output logic          prod_valid,
  input  logic          prod_ready,
  output logic [2*W:0]  prod,
  output logic          busy
);

  localparam int PW = 2 * W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   idx;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   pp_ext;
  logic            pp_fire;
  logic            prod_fire;
  logic            last;

  assign pp_ext    = PW'(pp);
  assign pp_fire   = pp_valid & pp_ready;
  assign prod_fire = prod_valid & prod_ready;
  assign last      = (idx == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (pp_fire && last) state_nx = DONE;
      DONE:  if (prod_fire)       state_nx = ACCUM;
    endcase
  end

  // Gated by rst so upstream sees no readiness during reset.
  always_comb begin
    pp_ready = 1'b0;
    unique case (state)
      ACCUM: pp_ready = rst;
      DONE:  pp_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      acc        <= '0;
      prod_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (pp_fire) begin
        acc  <= acc + (pp_ext << idx);
        busy <= 1'b1;
        if (last) begin
          idx        <= '0;
          prod_valid <= 1'b1;
        end else begin
          idx <= idx + CW'(1);
        end
      end
      if (prod_fire) begin
        prod_valid <= 1'b0;
        acc        <= '0;
        busy       <= 1'b0;
      end
    end
  end

  assign pp_index = idx;
  assign prod     = acc;

endmodule

// File: tb/tb_pp_accumulator.sv
// Scoreboard bench for pp_accumulator: directed
// partial-product sequences with hand-computed products.
module tb_pp_accumulator;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  typedef logic [W:0] pp_arr_t [W];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pp_valid = 1'b0;
  logic          pp_ready;
  logic [W:0]    pp = '0;
  logic [CW-1:0] pp_index;
  logic          prod_valid;
  logic          prod_ready = 1'b1;
  logic [2*W:0]  prod;
  logic          busy;

  pp_accumulator #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .pp_valid(pp_valid),
    .pp_ready(pp_ready),
    .pp(pp),
    .pp_index(pp_index),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod(prod),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int consumed = 0;
  int exp_idx = 0;
  int cyc = 0;
  logic pv_prev = 1'b0;
  logic [2*W:0] exp_q[$];
  int rise_q[$];

  pp_arr_t seq_a;
  pp_arr_t seq_1ff;
  pp_arr_t seq_0ff;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every product handshake against the scoreboard.
  always @(negedge clk) begin
    if (prod_valid && !pv_prev) rise_q.push_back(cyc);
    pv_prev = prod_valid;
    if (rst && prod_valid && prod_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL prod_unexpected actual=%0h required=none", prod);
      end else begin
        check("prod", 32'(prod), 32'(exp_q.pop_front()));
      end
      consumed++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pp(input logic [W:0] v);
    int n;
    n = 0;
    pp_valid = 1'b1;
    pp = v;
    while (!pp_ready && n < 50) begin
      step();
      n++;
    end
    check("pp_ready_wait", 32'(pp_ready), 32'd1);
    check("pp_index", 32'(pp_index), 32'(exp_idx));
    step();
    exp_idx = (exp_idx + 1) % W;
  endtask

  task automatic run_seq(input pp_arr_t v, input bit bubble,
                         input logic [2*W:0] exp, input bit hold);
    exp_q.push_back(exp);
    for (int i = 0; i < W; i++) begin
      if (bubble && i > 0) begin
        pp_valid = 1'b0;
        step();
      end
      push_pp(v[i]);
    end
    check("latency_valid", 32'(prod_valid), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_index", 32'(pp_index), 32'd0);
    if (!hold) pp_valid = 1'b0;
  endtask

  task automatic wait_prod(input int target);
    int n;
    n = 0;
    while (consumed < target && n < 60) begin
      step();
      n++;
    end
    check("handshake", 32'(consumed), 32'(target));
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(prod_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_a   = '{9'h000, 9'h000, 9'h0A5, 9'h0A5,
                9'h0A5, 9'h0A5, 9'h000, 9'h000};
    seq_1ff = '{default: 9'h1FF};
    seq_0ff = '{default: 9'h0FF};

    #12;
    check("rst_pp_ready", 32'(pp_ready), 32'd0);
    check("rst_prod_valid", 32'(prod_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pp_index", 32'(pp_index), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("idle_pp_ready", 32'(pp_ready), 32'd1);

    // 0xA5 x 0x3C
    run_seq(seq_a, 1'b0, 17'h026AC, 1'b0);
    wait_prod(1);

    // Maximum values
    run_seq(seq_1ff, 1'b0, 17'h1FD01, 1'b0);
    wait_prod(2);
    run_seq(seq_0ff, 1'b0, 17'h0FE01, 1'b0);
    wait_prod(3);

    // Backpressure with a pending pp held at the input
    prod_ready = 1'b0;
    run_seq(seq_a, 1'b0, 17'h026AC, 1'b1);
    pp = 9'h1FF;
    for (int i = 0; i < 5; i++) begin
      check("bp_prod", 32'(prod), 32'h026AC);
      check("bp_valid", 32'(prod_valid), 32'd1);
      check("bp_pp_ready", 32'(pp_ready), 32'd0);
      check("bp_pp_index", 32'(pp_index), 32'd0);
      step();
    end
    prod_ready = 1'b1;
    run_seq(seq_1ff, 1'b0, 17'h1FD01, 1'b0);
    wait_prod(5);

    // Bubbles between every accept
    run_seq(seq_a, 1'b1, 17'h026AC, 1'b0);
    wait_prod(6);

    // Reset mid-sequence
    for (int i = 0; i < 3; i++) push_pp(9'h0A5);
    pp_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_index", 32'(pp_index), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_pp_ready", 32'(pp_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pp_index", 32'(pp_index), 32'd0);
    check("arst_prod", 32'(prod), 32'd0);
    check("arst_valid", 32'(prod_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_idx = 0;
    step();
    run_seq(seq_0ff, 1'b0, 17'h0FE01, 1'b0);
    wait_prod(7);

    // Back-to-back with pp_valid and prod_ready tied high
    rise_q.delete();
    run_seq(seq_a, 1'b0, 17'h026AC, 1'b1);
    run_seq(seq_0ff, 1'b0, 17'h0FE01, 1'b0);
    wait_prod(9);
    if (rise_q.size() >= 2) begin
      check("b2b_spacing", 32'(rise_q[1] - rise_q[0]), 32'd9);
    end else begin
      checks++;
      failures++;
      $display("FAIL b2b_rises actual=%0d required=2", rise_q.size());
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
